// File: rtl/exe_stage.sv
// Execute stage of the LA32R pipeline: decode-to-execute register, one-hot ALU, data-SRAM request FSM.
// Define EXE_FWD_EN to drive execute-stage forwarding; otherwise decode stalls on any execute writer.
module exe_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_to_es_valid,
    output logic        es_allow_in,
    input  logic [31:0] ds_pc,
    input  logic [31:0] ds_alu_src1,
    input  logic [31:0] ds_alu_src2,
    input  logic [11:0] ds_alu_op,
    input  logic        ds_mem_re,
    input  logic [3:0]  ds_mem_we,
    input  logic [31:0] ds_st_data,
    input  logic [3:0]  ds_rf_we,
    input  logic [4:0]  ds_rf_waddr,
    input  logic        ms_allow_in,
    output logic        es_to_ms_valid,
    output logic [31:0] es_pc,
    output logic [31:0] es_result,
    output logic        es_mem_re,
    output logic [3:0]  es_rf_we,
    output logic [4:0]  es_rf_waddr,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    output logic [3:0]  es_fwd_we,
    output logic [4:0]  es_fwd_waddr,
    output logic [31:0] es_fwd_wdata,
    output logic        es_load_block
);

    localparam int NUM_OPS = 12;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [11:0] op;
        logic        mem_re;
        logic [3:0]  mem_we;
        logic [31:0] st_data;
        logic [3:0]  rf_we;
        logic [4:0]  rf_waddr;
    } es_payload_t;

    typedef enum logic {IDLE, SENT} req_state_t;

    es_payload_t es_r;
    logic        es_valid;
    req_state_t  state;
    logic        mem_op;
    logic        es_ready_go;
    logic [31:0] alu_result;
    logic [NUM_OPS-1:0][31:0] op_res;

    // Payload register: only the valid bit drops when decode has nothing to hand over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid <= 1'b0;
            es_r     <= '0;
            es_r.pc  <= RESET_PC;
        end else if (es_allow_in) begin
            es_valid <= ds_to_es_valid;
            if (ds_to_es_valid) begin
                es_r.pc       <= ds_pc;
                es_r.src1     <= ds_alu_src1;
                es_r.src2     <= ds_alu_src2;
                es_r.op       <= ds_alu_op;
                es_r.mem_re   <= ds_mem_re;
                es_r.mem_we   <= ds_mem_we;
                es_r.st_data  <= ds_st_data;
                es_r.rf_we    <= ds_rf_we;
                es_r.rf_waddr <= ds_rf_waddr;
            end
        end
    end

    assign op_res[0]  = es_r.src1 + es_r.src2;
    assign op_res[1]  = es_r.src1 - es_r.src2;
    assign op_res[2]  = {31'b0, $signed(es_r.src1) < $signed(es_r.src2)};
    assign op_res[3]  = {31'b0, es_r.src1 < es_r.src2};
    assign op_res[4]  = es_r.src1 & es_r.src2;
    assign op_res[5]  = ~(es_r.src1 | es_r.src2);
    assign op_res[6]  = es_r.src1 | es_r.src2;
    assign op_res[7]  = es_r.src1 ^ es_r.src2;
    assign op_res[8]  = es_r.src1 << es_r.src2[4:0];
    assign op_res[9]  = es_r.src1 >> es_r.src2[4:0];
    assign op_res[10] = $signed(es_r.src1) >>> es_r.src2[4:0];
    assign op_res[11] = es_r.src2;

    // AND-OR mux over the one-hot select; an all-zero op yields zero.
    always_comb begin
        alu_result = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (es_r.op[i]) alu_result = alu_result | op_res[i];
        end
    end

    assign mem_op = es_r.mem_re | (|es_r.mem_we);

    // Request FSM; SENT means this instruction's request is already accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (data_sram_req && data_sram_addr_ok && !ms_allow_in) state <= SENT;
                SENT: if (ms_allow_in) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign data_sram_req   = es_valid && mem_op && (state == IDLE);
    assign data_sram_wr    = |es_r.mem_we;
    assign data_sram_wstrb = es_r.mem_we;
    assign data_sram_addr  = op_res[0];
    assign data_sram_wdata = es_r.st_data;

    assign es_ready_go    = !mem_op || (state == SENT) || (data_sram_req && data_sram_addr_ok);
    assign es_allow_in    = !es_valid || (es_ready_go && ms_allow_in);
    assign es_to_ms_valid = es_valid && es_ready_go;

    assign es_pc       = es_r.pc;
    assign es_result   = alu_result;
    assign es_mem_re   = es_r.mem_re;
    assign es_rf_we    = es_r.rf_we;
    assign es_rf_waddr = es_r.rf_waddr;

`ifdef EXE_FWD_EN
    assign es_fwd_we     = es_valid ? es_r.rf_we : 4'b0;
    assign es_fwd_waddr  = es_r.rf_waddr;
    assign es_fwd_wdata  = alu_result;
    assign es_load_block = es_valid && es_r.mem_re;
`else
    assign es_fwd_we     = 4'b0;
    assign es_fwd_waddr  = 5'b0;
    assign es_fwd_wdata  = 32'b0;
    assign es_load_block = es_valid && (|es_r.rf_we);
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed cases plus randomized traffic against a behavioural model.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_to_es_valid;
    logic        es_allow_in;
    logic [31:0] ds_pc, ds_alu_src1, ds_alu_src2;
    logic [11:0] ds_alu_op;
    logic        ds_mem_re;
    logic [3:0]  ds_mem_we;
    logic [31:0] ds_st_data;
    logic [3:0]  ds_rf_we;
    logic [4:0]  ds_rf_waddr;
    logic        ms_allow_in;
    logic        es_to_ms_valid;
    logic [31:0] es_pc, es_result;
    logic        es_mem_re;
    logic [3:0]  es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic        data_sram_req, data_sram_wr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok;
    logic [3:0]  es_fwd_we;
    logic [4:0]  es_fwd_waddr;
    logic [31:0] es_fwd_wdata;
    logic        es_load_block;

    exe_stage dut (
        .clk(clk), .reset(reset), .ds_to_es_valid(ds_to_es_valid), .es_allow_in(es_allow_in),
        .ds_pc(ds_pc), .ds_alu_src1(ds_alu_src1), .ds_alu_src2(ds_alu_src2), .ds_alu_op(ds_alu_op),
        .ds_mem_re(ds_mem_re), .ds_mem_we(ds_mem_we), .ds_st_data(ds_st_data), .ds_rf_we(ds_rf_we),
        .ds_rf_waddr(ds_rf_waddr), .ms_allow_in(ms_allow_in), .es_to_ms_valid(es_to_ms_valid),
        .es_pc(es_pc), .es_result(es_result), .es_mem_re(es_mem_re), .es_rf_we(es_rf_we),
        .es_rf_waddr(es_rf_waddr), .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
        .es_fwd_we(es_fwd_we), .es_fwd_waddr(es_fwd_waddr), .es_fwd_wdata(es_fwd_wdata),
        .es_load_block(es_load_block)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, a, b, st;
        logic [11:0] op;
        logic        re;
        logic [3:0]  we, rfwe;
        logic [4:0]  wa;
    } instr_t;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU written straight from the operation table.
    function automatic logic [31:0] alu_model(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            12'h001: return a + b;
            12'h002: return a - b;
            12'h004: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            12'h008: return (a < b) ? 32'd1 : 32'd0;
            12'h010: return a & b;
            12'h020: return ~(a | b);
            12'h040: return a | b;
            12'h080: return a ^ b;
            12'h100: return a << b[4:0];
            12'h200: return a >> b[4:0];
            12'h400: return $unsigned($signed(a) >>> b[4:0]);
            12'h800: return b;
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) if (!reset && data_sram_req && data_sram_addr_ok) acc_cnt++;

    task automatic step(); @(posedge clk); #1; endtask

    task automatic drive(input instr_t i);
        ds_to_es_valid = 1'b1;
        ds_pc = i.pc; ds_alu_src1 = i.a; ds_alu_src2 = i.b; ds_alu_op = i.op;
        ds_mem_re = i.re; ds_mem_we = i.we; ds_st_data = i.st; ds_rf_we = i.rfwe; ds_rf_waddr = i.wa;
    endtask

    function automatic instr_t mk(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic re, input logic [3:0] we, input logic [31:0] st,
                                  input logic [3:0] rfwe, input logic [4:0] wa);
        instr_t i;
        i.pc = 32'h1c000100; i.op = op; i.a = a; i.b = b; i.re = re; i.we = we; i.st = st;
        i.rfwe = rfwe; i.wa = wa;
        return i;
    endfunction

    // Issue one ALU instruction and check its result the cycle after.
    task automatic alu_case(input string name, input logic [11:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        drive(mk(op, a, b, 1'b0, 4'h0, 32'h0, 4'hf, 5'd4));
        step();
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        chk({name, "_result"}, es_result, exp);
        chk({name, "_to_ms_valid"}, {31'b0, es_to_ms_valid}, 32'd1);
        step();
    endtask

    instr_t ds_i, cur;
    logic   ds_v, in_ex, req_done;

    function automatic instr_t rand_instr();
        instr_t i;
        int kind;
        kind = $urandom_range(0, 5);
        i.pc = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
        i.a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
        i.b  = ($urandom_range(0, 3) == 0) ? 32'hffff_ffff : $urandom;
        i.st = $urandom;
        i.wa = 5'($urandom_range(0, 31));
        i.re = 1'b0; i.we = 4'h0;
        if (kind == 0) begin
            i.op = 12'h001; i.re = 1'b1; i.rfwe = 4'hf;
        end else if (kind == 1) begin
            i.op = 12'h001; i.we = 4'($urandom_range(1, 15)); i.rfwe = 4'h0;
        end else begin
            i.op = ($urandom_range(0, 12) == 12) ? 12'h000 : 12'(1 << $urandom_range(0, 11));
            i.rfwe = $urandom_range(0, 1) ? 4'hf : 4'h0;
        end
        return i;
    endfunction

    initial begin
        int acc0;
        logic memop, can_leave, exp_allow, exp_req;
        logic [31:0] exp_res;

        reset = 1'b1; ds_to_es_valid = 1'b0; ds_pc = '0; ds_alu_src1 = '0; ds_alu_src2 = '0;
        ds_alu_op = '0; ds_mem_re = 1'b0; ds_mem_we = '0; ds_st_data = '0; ds_rf_we = '0;
        ds_rf_waddr = '0; ms_allow_in = 1'b1; data_sram_addr_ok = 1'b0;

        @(negedge clk);
        chk("rst_req", {31'b0, data_sram_req}, 32'd0);
        chk("rst_to_ms_valid", {31'b0, es_to_ms_valid}, 32'd0);
        chk("rst_allow_in", {31'b0, es_allow_in}, 32'd1);
        chk("rst_fwd_we", {28'b0, es_fwd_we}, 32'd0);
        chk("rst_load_block", {31'b0, es_load_block}, 32'd0);
        chk("rst_pc", es_pc, 32'h1c000000);
        step();
        reset = 1'b0;

        // add.w 5 + 7, also checks forwarding / stall behaviour for the build in use
        drive(mk(12'h001, 32'd5, 32'd7, 1'b0, 4'h0, 32'h0, 4'hf, 5'd3));
        step();
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        chk("add_result", es_result, 32'd12);
        chk("add_to_ms_valid", {31'b0, es_to_ms_valid}, 32'd1);
`ifdef EXE_FWD_EN
        chk("add_fwd_wdata", es_fwd_wdata, 32'd12);
        chk("add_fwd_we", {28'b0, es_fwd_we}, 32'hf);
        chk("add_load_block", {31'b0, es_load_block}, 32'd0);
`else
        chk("add_fwd_we", {28'b0, es_fwd_we}, 32'd0);
        chk("add_fwd_wdata", es_fwd_wdata, 32'd0);
        chk("add_load_block", {31'b0, es_load_block}, 32'd1);
`endif
        step();

        alu_case("sra",  12'h400, 32'h8000_0000, 32'd4, 32'hf800_0000);
        alu_case("sltu", 12'h008, 32'd1, 32'hffff_ffff, 32'd1);
        alu_case("slt",  12'h004, 32'd1, 32'hffff_ffff, 32'd0);
        alu_case("zero_op", 12'h000, 32'd9, 32'd9, 32'd0);

        // st.w with addr_ok held low for three cycles
        data_sram_addr_ok = 1'b0;
        drive(mk(12'h001, 32'h1000, 32'd8, 1'b0, 4'hf, 32'hdeadbeef, 4'h0, 5'd0));
        step();
        ds_to_es_valid = 1'b0;
        acc0 = acc_cnt;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("st_req_held", {31'b0, data_sram_req}, 32'd1);
            chk("st_addr", data_sram_addr, 32'h1008);
            chk("st_wstrb", {28'b0, data_sram_wstrb}, 32'hf);
            chk("st_wdata", data_sram_wdata, 32'hdeadbeef);
            chk("st_allow_in_low", {31'b0, es_allow_in}, 32'd0);
            step();
        end
        data_sram_addr_ok = 1'b1;
        @(negedge clk);
        chk("st_wr", {31'b0, data_sram_wr}, 32'd1);
        chk("st_leave", {31'b0, es_to_ms_valid}, 32'd1);
        chk("st_allow_in", {31'b0, es_allow_in}, 32'd1);
        step();
        @(negedge clk);
        chk("st_req_drop", {31'b0, data_sram_req}, 32'd0);
        chk("st_one_request", acc_cnt - acc0, 32'd1);
        step();

        // ld.w accepted while memory stage is blocked for two cycles
        ms_allow_in = 1'b0;
        data_sram_addr_ok = 1'b1;
        drive(mk(12'h001, 32'h2000, 32'd4, 1'b1, 4'h0, 32'h0, 4'hf, 5'd5));
        step();
        ds_to_es_valid = 1'b0;
        acc0 = acc_cnt;
        @(negedge clk);
        chk("ld_req", {31'b0, data_sram_req}, 32'd1);
        chk("ld_addr", data_sram_addr, 32'h2004);
        chk("ld_load_block", {31'b0, es_load_block}, 32'd1);
        step();
        @(negedge clk);
        chk("ld_sent_req", {31'b0, data_sram_req}, 32'd0);
        chk("ld_sent_block", {31'b0, es_load_block}, 32'd1);
        chk("ld_sent_allow_in", {31'b0, es_allow_in}, 32'd0);
        step();
        ms_allow_in = 1'b1;
        @(negedge clk);
        chk("ld_leave", {31'b0, es_to_ms_valid}, 32'd1);
        chk("ld_allow_in", {31'b0, es_allow_in}, 32'd1);
        step();
        @(negedge clk);
        chk("ld_gone", {31'b0, es_load_block}, 32'd0);
        chk("ld_one_request", acc_cnt - acc0, 32'd1);
        step();

        // reset in the middle of a pending request
        data_sram_addr_ok = 1'b0;
        drive(mk(12'h001, 32'h3000, 32'd0, 1'b1, 4'h0, 32'h0, 4'hf, 5'd6));
        step();
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        chk("mid_req", {31'b0, data_sram_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_req", {31'b0, data_sram_req}, 32'd0);
        chk("mid_rst_to_ms", {31'b0, es_to_ms_valid}, 32'd0);
        chk("mid_rst_allow_in", {31'b0, es_allow_in}, 32'd1);
        step();
        reset = 1'b0;
        data_sram_addr_ok = 1'b1;
        drive(mk(12'h001, 32'h4000, 32'd12, 1'b1, 4'h0, 32'h0, 4'hf, 5'd7));
        step();
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_req", {31'b0, data_sram_req}, 32'd1);
        chk("post_rst_addr", data_sram_addr, 32'h400c);
        chk("post_rst_leave", {31'b0, es_to_ms_valid}, 32'd1);
        step();

        // randomized traffic against the behavioural model
        in_ex = 1'b0; req_done = 1'b0; ds_v = 1'b0;
        ds_i = rand_instr();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (ds_v) drive(ds_i); else ds_to_es_valid = 1'b0;
            ms_allow_in = ($urandom_range(0, 3) != 0);
            data_sram_addr_ok = ($urandom_range(0, 2) != 0);
            @(negedge clk);

            memop = in_ex && (cur.re || (|cur.we));
            exp_req = memop && !req_done;
            can_leave = in_ex && (!memop || req_done || data_sram_addr_ok);
            exp_allow = !in_ex || (can_leave && ms_allow_in);
            exp_res = alu_model(cur.op, cur.a, cur.b);

            chk("r_req", {31'b0, data_sram_req}, {31'b0, exp_req});
            chk("r_to_ms_valid", {31'b0, es_to_ms_valid}, {31'b0, can_leave});
            chk("r_allow_in", {31'b0, es_allow_in}, {31'b0, exp_allow});
            if (exp_req) begin
                chk("r_addr", data_sram_addr, cur.a + cur.b);
                chk("r_wdata", data_sram_wdata, cur.st);
                chk("r_wstrb", {28'b0, data_sram_wstrb}, {28'b0, cur.we});
                chk("r_wr", {31'b0, data_sram_wr}, {31'b0, |cur.we});
            end
            if (can_leave) begin
                chk("r_pc", es_pc, cur.pc);
                chk("r_result", es_result, exp_res);
                chk("r_mem_re", {31'b0, es_mem_re}, {31'b0, cur.re});
                chk("r_rf_we", {28'b0, es_rf_we}, {28'b0, cur.rfwe});
                chk("r_rf_waddr", {27'b0, es_rf_waddr}, {27'b0, cur.wa});
            end
`ifdef EXE_FWD_EN
            chk("r_fwd_we", {28'b0, es_fwd_we}, in_ex ? {28'b0, cur.rfwe} : 32'd0);
            chk("r_load_block", {31'b0, es_load_block}, {31'b0, in_ex && cur.re});
            if (in_ex) begin
                chk("r_fwd_waddr", {27'b0, es_fwd_waddr}, {27'b0, cur.wa});
                chk("r_fwd_wdata", es_fwd_wdata, exp_res);
            end
`else
            chk("r_fwd_we", {28'b0, es_fwd_we}, 32'd0);
            chk("r_fwd_waddr", {27'b0, es_fwd_waddr}, 32'd0);
            chk("r_fwd_wdata", es_fwd_wdata, 32'd0);
            chk("r_load_block", {31'b0, es_load_block}, {31'b0, in_ex && (|cur.rfwe)});
`endif

            if (exp_req && data_sram_addr_ok) req_done = 1'b1;
            if (can_leave && ms_allow_in) begin
                in_ex = 1'b0; req_done = 1'b0;
            end
            if (ds_v && exp_allow) begin
                in_ex = 1'b1; req_done = 1'b0; cur = ds_i;
                ds_i = rand_instr();
                ds_v = ($urandom_range(0, 3) != 0);
            end else if (!ds_v) begin
                ds_v = ($urandom_range(0, 3) != 0);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
